// File: rtl/calc_phase_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// calc_phase_seq_if : sample-buffer read port plus client-engine bus
// Revision : 1.0
// ============================================================================
interface calc_phase_seq_if #(
  parameter int NPHASE     = 2,
  parameter int AW         = 7,
  parameter int DATA_WIDTH = 8
);
  logic                   mem_rd_rqst;
  logic [AW-1:0]          mem_addr;
  logic                   mem_data_rdy;
  logic [DATA_WIDTH-1:0]  mem_data;
  logic [NPHASE-1:0]      cl_start;
  logic [NPHASE-1:0]      cl_rd_rqst;
  logic [NPHASE*AW-1:0]   cl_addr;
  logic [NPHASE-1:0]      cl_data_rdy;
  logic [DATA_WIDTH-1:0]  cl_data;
  logic [NPHASE-1:0]      cl_done;

  modport master (
    output mem_rd_rqst, mem_addr, cl_start, cl_data_rdy, cl_data,
    input  mem_data_rdy, mem_data, cl_rd_rqst, cl_addr, cl_done
  );

  modport slave (
    input  mem_rd_rqst, mem_addr, cl_start, cl_data_rdy, cl_data,
    output mem_data_rdy, mem_data, cl_rd_rqst, cl_addr, cl_done
  );
endinterface
`default_nettype wire

// File: rtl/calc_phase_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// calc_phase_seq : runs NPHASE client engines in turn per sample window and
//                  routes the buffer read port; optional CALC_SEQ_STATS_EN.
// Revision : 1.0
// ============================================================================
module calc_phase_seq #(
  parameter int NPHASE     = 2,
  parameter int POPSIZE    = 100,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = $clog2(POPSIZE),
  parameter int TIMEOUT    = 4096
`ifdef CALC_SEQ_STATS_EN
  , parameter int CW       = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  calc_phase_seq_if.master            bus,
  output logic [$clog2(NPHASE)-1:0]   phase,
  output logic                        busy,
  output logic                        calc_done,
  output logic                        timeout_err
`ifdef CALC_SEQ_STATS_EN
  , output logic [NPHASE*CW-1:0]      phase_cycles
`endif
);
  localparam int PW = $clog2(NPHASE);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic [2:0]        r_state;
  logic [PW-1:0]     r_phase;
  logic              r_pending;
  logic [WW-1:0]     r_wdog;

  logic              w_run;
  logic              w_last;
  logic              w_wdog_exp;
  logic [NPHASE-1:0] w_onehot;
  logic [AW-1:0]     w_cl_addr [NPHASE];

  assign w_run      = (r_state == S_RUN);
  assign w_last     = (r_phase == PW'(NPHASE - 1));
  assign w_wdog_exp = (r_wdog == WW'(TIMEOUT - 1));
  assign w_onehot   = NPHASE'(1) << r_phase;

  for (genvar p = 0; p < NPHASE; p++) begin : g_addr
    assign w_cl_addr[p] = bus.cl_addr[p*AW +: AW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_pending <= 1'b0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LAUNCH;
            r_phase <= '0;
          end
        end
        S_LAUNCH: begin
          r_wdog  <= '0;
          r_state <= S_RUN;
          if (start) r_pending <= 1'b1;
        end
        S_RUN: begin
          r_wdog <= r_wdog + WW'(1);
          if (start) r_pending <= 1'b1;
          // A completing client wins over a watchdog expiring on the same cycle
          if (bus.cl_done[r_phase])
            r_state <= S_ADVANCE;
          else if (w_wdog_exp)
            r_state <= S_ERR;
        end
        S_ADVANCE: begin
          if (start) r_pending <= 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_phase <= '0;
          end else begin
            r_state <= S_LAUNCH;
            r_phase <= r_phase + PW'(1);
          end
        end
        S_DONE: begin
          r_phase <= '0;
          if (r_pending || start) begin
            r_state   <= S_LAUNCH;
            r_pending <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          r_phase   <= '0;
          r_pending <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read port is only connected to the active client while it is running
  assign bus.mem_rd_rqst = w_run & bus.cl_rd_rqst[r_phase];
  assign bus.mem_addr    = w_run ? w_cl_addr[r_phase] : '0;
  assign bus.cl_data_rdy = (w_run && bus.mem_data_rdy) ? w_onehot : '0;
  assign bus.cl_start    = (r_state == S_LAUNCH) ? w_onehot : '0;
  assign bus.cl_data     = bus.mem_data;

  assign phase       = r_phase;
  assign busy        = (r_state != S_IDLE);
  assign calc_done   = (r_state == S_DONE);
  assign timeout_err = (r_state == S_ERR);

`ifdef CALC_SEQ_STATS_EN
  for (genvar p = 0; p < NPHASE; p++) begin : g_stats
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_cnt <= '0;
      else if (r_state == S_LAUNCH && r_phase == '0)
        r_cnt <= '0;
      else if (w_run && r_phase == PW'(p) && r_cnt != '1)
        r_cnt <= r_cnt + CW'(1);
    end
    assign phase_cycles[p*CW +: CW] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_phase_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_calc_phase_seq : vector table, directed corner cases and randomized
//                     traffic against a timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_calc_phase_seq;
  localparam int NP  = 3;
  localparam int DW  = 8;
  localparam int AWL = 7;
  localparam int TO  = 16;
  localparam int CWL = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] phase;
  logic busy, calc_done, timeout_err;
`ifdef CALC_SEQ_STATS_EN
  logic [NP*CWL-1:0] phase_cycles;
`endif

  calc_phase_seq_if #(.NPHASE(NP), .AW(AWL), .DATA_WIDTH(DW)) bus ();

  calc_phase_seq #(
    .NPHASE(NP), .POPSIZE(100), .DATA_WIDTH(DW), .AW(AWL), .TIMEOUT(TO)
`ifdef CALC_SEQ_STATS_EN
    , .CW(CWL)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .phase(phase), .busy(busy), .calc_done(calc_done), .timeout_err(timeout_err)
`ifdef CALC_SEQ_STATS_EN
    , .phase_cycles(phase_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       st;
    logic [2:0] done;
    logic [2:0] rd;
    logic [2:0] e_start;
    logic       e_busy;
    logic       e_cdone;
    logic       e_rd;
    logic [6:0] e_addr;
    logic [2:0] e_rdy;
    int         e_phase;
  } vec_t;

  function automatic vec_t mk(logic st, logic [2:0] done, logic [2:0] rd, logic [2:0] es,
                              logic eb, logic ec, logic er, logic [6:0] ea,
                              logic [2:0] ey, int ep);
    vec_t v;
    v.st = st; v.done = done; v.rd = rd; v.e_start = es; v.e_busy = eb;
    v.e_cdone = ec; v.e_rd = er; v.e_addr = ea; v.e_rdy = ey; v.e_phase = ep;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [24];

  // Timeline reference model state
  int m_win, m_ph, m_L, m_d, m_pend;
  int m_pc [NP];

  initial begin
    // Client p reads from 7 / 42 / 99; phase lengths below are in RUN cycles
    tbl[0]  = mk(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 7'd0,  3'd0, 0);
    tbl[1]  = mk(0, 3'd0, 3'd7, 3'd1, 1, 0, 0, 7'd0,  3'd0, 0);
    tbl[2]  = mk(0, 3'd2, 3'd3, 3'd0, 1, 0, 1, 7'd7,  3'd1, 0);
    tbl[3]  = mk(0, 3'd1, 3'd2, 3'd0, 1, 0, 0, 7'd7,  3'd1, 0);
    tbl[4]  = mk(0, 3'd7, 3'd7, 3'd0, 1, 0, 0, 7'd0,  3'd0, 0);
    tbl[5]  = mk(0, 3'd0, 3'd7, 3'd2, 1, 0, 0, 7'd0,  3'd0, 1);
    tbl[6]  = mk(0, 3'd0, 3'd3, 3'd0, 1, 0, 1, 7'd42, 3'd2, 1);
    tbl[7]  = mk(0, 3'd2, 3'd1, 3'd0, 1, 0, 0, 7'd42, 3'd2, 1);
    tbl[8]  = mk(0, 3'd0, 3'd7, 3'd0, 1, 0, 0, 7'd0,  3'd0, 1);
    tbl[9]  = mk(1, 3'd0, 3'd0, 3'd4, 1, 0, 0, 7'd0,  3'd0, 2);
    tbl[10] = mk(0, 3'd4, 3'd4, 3'd0, 1, 0, 1, 7'd99, 3'd4, 2);
    tbl[11] = mk(1, 3'd0, 3'd4, 3'd0, 1, 0, 0, 7'd0,  3'd0, 2);
    tbl[12] = mk(0, 3'd0, 3'd0, 3'd0, 1, 1, 0, 7'd0,  3'd0, -1);
    tbl[13] = mk(0, 3'd0, 3'd0, 3'd1, 1, 0, 0, 7'd0,  3'd0, 0);
    tbl[14] = mk(0, 3'd1, 3'd1, 3'd0, 1, 0, 1, 7'd7,  3'd1, 0);
    tbl[15] = mk(0, 3'd0, 3'd0, 3'd0, 1, 0, 0, 7'd0,  3'd0, 0);
    tbl[16] = mk(0, 3'd0, 3'd0, 3'd2, 1, 0, 0, 7'd0,  3'd0, 1);
    tbl[17] = mk(0, 3'd2, 3'd2, 3'd0, 1, 0, 1, 7'd42, 3'd2, 1);
    tbl[18] = mk(0, 3'd0, 3'd0, 3'd0, 1, 0, 0, 7'd0,  3'd0, 1);
    tbl[19] = mk(0, 3'd0, 3'd0, 3'd4, 1, 0, 0, 7'd0,  3'd0, 2);
    tbl[20] = mk(0, 3'd4, 3'd0, 3'd0, 1, 0, 0, 7'd99, 3'd4, 2);
    tbl[21] = mk(0, 3'd0, 3'd0, 3'd0, 1, 0, 0, 7'd0,  3'd0, 2);
    tbl[22] = mk(0, 3'd0, 3'd0, 3'd0, 1, 1, 0, 7'd0,  3'd0, -1);
    tbl[23] = mk(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 7'd0,  3'd0, 0);

    rst = 1'b1;
    start = 1'b0;
    bus.mem_data_rdy = 1'b0;
    bus.mem_data = '0;
    bus.cl_rd_rqst = '0;
    bus.cl_addr = '0;
    bus.cl_done = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_cl_start", bus.cl_start, 0);
    chk("rst_calc_done", calc_done, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_rd", bus.mem_rd_rqst, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rdy", bus.cl_data_rdy, 0);
`ifdef CALC_SEQ_STATS_EN
    chk("rst_stats", phase_cycles, 0);
`endif
    tick();
    rst = 1'b0;

    // ---------------- vector table ----------------
    bus.cl_addr = {7'd99, 7'd42, 7'd7};
    bus.mem_data_rdy = 1'b1;
    bus.mem_data = 8'hA5;
    for (int i = 0; i < 24; i++) begin
      tick();
      start = tbl[i].st;
      bus.cl_done = tbl[i].done;
      bus.cl_rd_rqst = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_cl_start", i), bus.cl_start, tbl[i].e_start);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_calc_done", i), calc_done, tbl[i].e_cdone);
      chk($sformatf("tbl%0d_timeout", i), timeout_err, 0);
      chk($sformatf("tbl%0d_rd", i), bus.mem_rd_rqst, tbl[i].e_rd);
      chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_rdy", i), bus.cl_data_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_data", i), bus.cl_data, 8'hA5);
      if (tbl[i].e_phase >= 0)
        chk($sformatf("tbl%0d_phase", i), phase, tbl[i].e_phase);
`ifdef CALC_SEQ_STATS_EN
      if (i == 23)
        chk("tbl_stats", phase_cycles, {4'd1, 4'd1, 4'd1});
`endif
    end

    // ---------------- watchdog expiry ----------------
    tick();
    start = 1'b1;
    bus.cl_done = '0;
    bus.cl_rd_rqst = '0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      start = 1'b0;
      #1;
      chk($sformatf("to_k%0d_err", k), timeout_err, (k == 18));
      chk($sformatf("to_k%0d_calc_done", k), calc_done, 0);
      if (k == 1) chk("to_cl_start", bus.cl_start, 3'b001);
      if (k == 19) chk("to_idle_busy", busy, 0);
`ifdef CALC_SEQ_STATS_EN
      if (k == 19) chk("to_stats_sat", phase_cycles, {4'd0, 4'd0, 4'd15});
`endif
    end

    // ---------------- reset during phase 1 ----------------
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cl_done = 3'b001;
    for (int k = 2; k <= 5; k++) tick();
    bus.cl_rd_rqst = 3'b010;
    bus.mem_data_rdy = 1'b1;
    #1;
    chk("mr_pre_phase", phase, 1);
    chk("mr_pre_rd", bus.mem_rd_rqst, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_phase", phase, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rd", bus.mem_rd_rqst, 0);
    chk("mr_addr", bus.mem_addr, 0);
    chk("mr_rdy", bus.cl_data_rdy, 0);
    chk("mr_cl_start", bus.cl_start, 0);
`ifdef CALC_SEQ_STATS_EN
    chk("mr_stats", phase_cycles, 0);
`endif
    tick();
    rst = 1'b0;
    bus.cl_done = '0;
    bus.cl_rd_rqst = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cl_done = 3'b111;
    #1;
    chk("mr_relaunch", bus.cl_start, 3'b001);
    for (int k = 0; k < 14; k++) tick();
    chk("mr_finish_busy", busy, 0);

    // ---------------- randomized traffic vs timeline model ----------------
    m_win = 0; m_ph = 0; m_L = 0; m_d = 0; m_pend = 0;
    for (int p = 0; p < NP; p++) m_pc[p] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int o, kind;
      logic s, rdy;
      logic [2:0] rd, dn;
      logic [20:0] ad;
      logic [7:0] dat;
      tick();
      o = cyc - m_L;
      // kind: 0 idle, 1 launch, 2 run, 3 gap, 4 done, 5 watchdog error
      if (m_win == 0)       kind = 0;
      else if (o == 0)      kind = 1;
      else if (m_d > TO)    kind = (o <= TO) ? 2 : 5;
      else                  kind = (o <= m_d) ? 2 : ((o == m_d + 1) ? 3 : 4);
      s   = ($urandom_range(0, 11) == 0);
      rd  = 3'($urandom);
      ad  = 21'($urandom);
      rdy = 1'($urandom);
      dat = 8'($urandom);
      dn  = 3'($urandom);
      if (kind == 2) dn[m_ph] = (o == m_d);
      start = s;
      bus.cl_rd_rqst = rd;
      bus.cl_addr = ad;
      bus.mem_data_rdy = rdy;
      bus.mem_data = dat;
      bus.cl_done = dn;
      #1;
      chk("rnd_cl_start", bus.cl_start, (kind == 1) ? (3'b001 << m_ph) : 3'b000);
      chk("rnd_busy", busy, (m_win != 0));
      chk("rnd_calc_done", calc_done, (kind == 4));
      chk("rnd_timeout", timeout_err, (kind == 5));
      chk("rnd_rd", bus.mem_rd_rqst, (kind == 2) ? rd[m_ph] : 1'b0);
      chk("rnd_addr", bus.mem_addr, (kind == 2) ? ad[m_ph*AWL +: AWL] : 7'd0);
      chk("rnd_rdy", bus.cl_data_rdy, (kind == 2 && rdy) ? (3'b001 << m_ph) : 3'b000);
      chk("rnd_data", bus.cl_data, dat);
      if (kind <= 3) chk("rnd_phase", phase, (kind == 0) ? 0 : m_ph);
`ifdef CALC_SEQ_STATS_EN
      for (int p = 0; p < NP; p++)
        chk($sformatf("rnd_stats%0d", p), phase_cycles[p*CWL +: CWL], m_pc[p]);
`endif
      case (kind)
        0: if (s) begin
             m_win = 1; m_ph = 0; m_L = cyc + 1; m_d = $urandom_range(1, 20);
           end
        1: begin
             if (s) m_pend = 1;
             if (m_ph == 0) for (int p = 0; p < NP; p++) m_pc[p] = 0;
           end
        2: begin
             if (s) m_pend = 1;
             if (m_pc[m_ph] < (1 << CWL) - 1) m_pc[m_ph]++;
           end
        3: begin
             if (s) m_pend = 1;
             if (m_ph < NP - 1) begin
               m_ph++; m_L = cyc + 1; m_d = $urandom_range(1, 20);
             end
           end
        4: if (m_pend != 0 || s) begin
             m_ph = 0; m_L = cyc + 1; m_d = $urandom_range(1, 20); m_pend = 0;
           end else begin
             m_win = 0;
           end
        default: begin
             m_win = 0; m_pend = 0; m_ph = 0;
           end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
